// File: rtl/ee357_mc_control_pkg.sv
// Shared encodings for the ee357 multicycle control unit: state codes,
// opcodes, datapath select encodings and the packed control word.
package ee357_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/ee357_mc_control_if.sv
// Control bus between the ee357 control unit (master) and the datapath
// (slave). mem_ready only exists when EE357_MC_MEM_WAIT_EN is defined.
interface ee357_mc_control_if;
    logic [5:0] op;
`ifdef EE357_MC_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op,
`ifdef EE357_MC_MEM_WAIT_EN
        input  mem_ready,
`endif
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output op,
`ifdef EE357_MC_MEM_WAIT_EN
        output mem_ready,
`endif
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/ee357_mc_control_output_decode.sv
// Moore output decode: maps the registered state to the datapath control
// word. Unused state codes produce an all-zero word.
module ee357_mc_output_decode
    import ee357_mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state control word; everything not listed for a state stays 0.
    always_comb begin
        // NOTE: the all-zero default first means every path assigns ctrl, so no latch.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
            end
            S_DECODE:    ctrl.alu_src_b = SRC_B_IMM_SH2;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALU_OUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_ADDI_WB:   ctrl.reg_write = 1'b1;
            default:     ctrl = '0;
        endcase
    end

endmodule

// File: rtl/ee357_mc_control.sv
// Multicycle MIPS-subset control unit: state register, next-state logic and
// strobe gating. Optional feature macro: EE357_MC_MEM_WAIT_EN adds the
// mem_ready input and holds FETCH/MEM_READ/MEM_WRITE until memory is ready.
module ee357_mc_control
    import ee357_mc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    ee357_mc_control_if.master      bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   mem_ready;
    logic   fetch_stall;
    logic   strobe_en;
    logic   legal_op;

`ifdef EE357_MC_MEM_WAIT_EN
    assign mem_ready = bus.mem_ready;
`else
    assign mem_ready = 1'b1;
`endif

    // State register; reset wins over any in-flight instruction.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps the register update race-free.
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state selection from the current state, opcode and memory handshake.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (bus.op == OP_LW)      state_d = S_MEM_READ;
                else if (bus.op == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = S_FETCH;
            end
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    ee357_mc_output_decode u_output_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Opcode legality, only meaningful while decoding.
    always_comb begin
        legal_op = 1'b0;
        case (bus.op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal_op = 1'b1;
            default:                                       legal_op = 1'b0;
        endcase
    end

    // A stalled fetch keeps the read going but must not load IR or advance PC.
    assign fetch_stall = (state_q == S_FETCH) && !mem_ready;
    assign strobe_en   = !rst;

    assign bus.pc_write      = ctrl.pc_write      & strobe_en & !fetch_stall;
    assign bus.ir_write      = ctrl.ir_write      & strobe_en & !fetch_stall;
    assign bus.pc_write_cond = ctrl.pc_write_cond & strobe_en;
    assign bus.mem_read      = ctrl.mem_read      & strobe_en;
    assign bus.mem_write     = ctrl.mem_write     & strobe_en;
    assign bus.reg_write     = ctrl.reg_write     & strobe_en;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = (state_q == S_DECODE) && !legal_op;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_ee357_mc_control.sv
// Directed bench for ee357_mc_control. Each observation is a 21-bit word:
// {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
//  illegal_op}. Expected words are written out by hand per state.
module tb_ee357_mc_control;
    import ee357_mc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ee357_mc_control_if bus_if ();

    ee357_mc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    //                                           pcw..asa       asb    aop    psrc   ill
    localparam logic [20:0] E_FETCH     = {S_FETCH,     10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_FETCH_RST = {S_FETCH,     10'b0000000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_FETCH_WT  = {S_FETCH,     10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_DECODE    = {S_DECODE,    10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_DECODE_IL = {S_DECODE,    10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [20:0] E_MEM_ADDR  = {S_MEM_ADDR,  10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_MEM_READ  = {S_MEM_READ,  10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_MEM_WB    = {S_MEM_WB,    10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_MEM_WRITE = {S_MEM_WRITE, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_R_EXEC    = {S_R_EXEC,    10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [20:0] E_R_WB      = {S_R_WB,      10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_BRANCH    = {S_BRANCH,    10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [20:0] E_JUMP      = {S_JUMP,      10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [20:0] E_ADDI_EXEC = {S_ADDI_EXEC, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] E_ADDI_WB   = {S_ADDI_WB,   10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};

    function automatic logic [20:0] obs();
        return {bus_if.state, bus_if.pc_write, bus_if.pc_write_cond, bus_if.i_or_d,
                bus_if.mem_read, bus_if.mem_write, bus_if.ir_write, bus_if.mem_to_reg,
                bus_if.reg_dst, bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b,
                bus_if.alu_op, bus_if.pc_source, bus_if.illegal_op};
    endfunction

    // Advance one clock and let the combinational outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (obs() !== E_FETCH_RST) begin
            errors++;
            $display("FAIL reset_cycle1 got %h want %h", obs(), E_FETCH_RST);
        end
        step();
        checks++;
        if (obs() !== E_FETCH_RST) begin
            errors++;
            $display("FAIL reset_cycle2 got %h want %h", obs(), E_FETCH_RST);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== E_FETCH) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs(), E_FETCH);
        end
    endtask

    // Runs one instruction from FETCH; seq holds n expected words, first in
    // the most significant slot, the last being the return to FETCH.
    task automatic test_sequence(input string name, input logic [5:0] opcode,
                                 input int n, input logic [125:0] seq);
        logic [20:0] want;
        bus_if.op = opcode;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            want = seq[(n-1-i)*21 +: 21];
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL %s cycle%0d got %h want %h", name, i + 1, obs(), want);
            end
        end
    endtask

    task automatic test_instructions();
        test_sequence("lw", OP_LW, 6,
            126'({E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_READ, E_MEM_WB, E_FETCH}));
        test_sequence("sw", OP_SW, 5,
            126'({E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_WRITE, E_FETCH}));
        test_sequence("rtype", OP_RTYPE, 5,
            126'({E_FETCH, E_DECODE, E_R_EXEC, E_R_WB, E_FETCH}));
        test_sequence("beq", OP_BEQ, 4,
            126'({E_FETCH, E_DECODE, E_BRANCH, E_FETCH}));
        test_sequence("j", OP_J, 4,
            126'({E_FETCH, E_DECODE, E_JUMP, E_FETCH}));
        test_sequence("addi", OP_ADDI, 5,
            126'({E_FETCH, E_DECODE, E_ADDI_EXEC, E_ADDI_WB, E_FETCH}));
    endtask

    task automatic test_illegal();
        test_sequence("illegal_3f", 6'b111111, 3, 126'({E_FETCH, E_DECODE_IL, E_FETCH}));
        test_sequence("illegal_01", 6'b000001, 3, 126'({E_FETCH, E_DECODE_IL, E_FETCH}));
    endtask

    // An opcode that changes to a non-memory op during MEM_ADDR falls back to FETCH.
    task automatic test_mem_addr_escape();
        test_sequence("mem_addr_pre", OP_LW, 3, 126'({E_FETCH, E_DECODE, E_MEM_ADDR}));
        bus_if.op = OP_ADDI;
        step();
        checks++;
        if (obs() !== E_FETCH) begin
            errors++;
            $display("FAIL mem_addr_escape got %h want %h", obs(), E_FETCH);
        end
    endtask

    task automatic test_reset_mid_instr();
        test_sequence("rst_mid_pre", OP_RTYPE, 3, 126'({E_FETCH, E_DECODE, E_R_EXEC}));
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== E_R_EXEC) begin
            errors++;
            $display("FAIL rst_mid_exec got %h want %h", obs(), E_R_EXEC);
        end
        step();
        checks++;
        if (obs() !== E_FETCH_RST) begin
            errors++;
            $display("FAIL rst_mid_after_edge got %h want %h", obs(), E_FETCH_RST);
        end
        step();
        checks++;
        if (bus_if.reg_write !== 1'b0 || obs() !== E_FETCH_RST) begin
            errors++;
            $display("FAIL rst_mid_held got %h want %h", obs(), E_FETCH_RST);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== E_FETCH) begin
            errors++;
            $display("FAIL rst_mid_release got %h want %h", obs(), E_FETCH);
        end
    endtask

`ifdef EE357_MC_MEM_WAIT_EN
    task automatic test_mem_wait();
        bus_if.op = OP_SW;
        bus_if.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs() !== E_FETCH_WT) begin
                errors++;
                $display("FAIL fetch_wait%0d got %h want %h", i, obs(), E_FETCH_WT);
            end
            step();
        end
        bus_if.mem_ready = 1'b1;
        #1;
        checks++;
        if (obs() !== E_FETCH) begin
            errors++;
            $display("FAIL fetch_ready got %h want %h", obs(), E_FETCH);
        end
        test_sequence("wait_sw_pre", OP_SW, 4,
            126'({E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_WRITE}));
        bus_if.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs() !== E_MEM_WRITE) begin
                errors++;
                $display("FAIL mem_write_wait%0d got %h want %h", i, obs(), E_MEM_WRITE);
            end
            step();
        end
        checks++;
        if (obs() !== E_MEM_WRITE) begin
            errors++;
            $display("FAIL mem_write_hold got %h want %h", obs(), E_MEM_WRITE);
        end
        bus_if.mem_ready = 1'b1;
        step();
        checks++;
        if (obs() !== E_FETCH) begin
            errors++;
            $display("FAIL mem_write_release got %h want %h", obs(), E_FETCH);
        end
    endtask
`endif

    initial begin
        bus_if.op = OP_RTYPE;
`ifdef EE357_MC_MEM_WAIT_EN
        bus_if.mem_ready = 1'b1;
`endif
        test_reset();
        test_instructions();
        test_illegal();
        test_mem_addr_escape();
        test_reset_mid_instr();
`ifdef EE357_MC_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ee357_mc_control.md
# ee357_mc_control

Multicycle control unit for the 32-bit MIPS-subset datapath. It is a Moore state machine that sequences instruction fetch, decode, execute, memory and write-back. It drives every datapath enable and every mux select, including the 2-bit `alu_src_b` and `pc_source` selects of the 4x32 muxes. It sits beside the datapath, takes only the IR opcode field (and optionally a memory-ready strobe), and owns no data.

## Interface
Parameters:
- none; all encodings live in the package.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  6  opcode, IR[31:26].
- `mem_ready`  in  1  memory access complete (present only with `EE357_MC_MEM_WAIT_EN`).
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load.
- `mem_to_reg`  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = A reg.
- `alu_src_b`  out  2  ALU B input: 00 = B reg, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct field.
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  high during DECODE when `op` is unsupported.
- `state`  out  4  current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States and their asserted outputs. Any output not listed is 0; an unlisted select is don't-care and is driven 0.
  - FETCH: mem_read, ir_write, pc_write, alu_src_b=01. Next state is DECODE.
  - DECODE: alu_src_b=11. Next state by opcode:
    - lw/sw → MEM_ADDR
    - R → R_EXEC
    - beq → BRANCH
    - j → JUMP
    - addi → ADDI_EXEC
    - other → FETCH, with illegal_op=1
  - MEM_ADDR: alu_src_a, alu_src_b=10. Next state is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: mem_read, i_or_d. Next state is MEM_WB.
  - MEM_WB: reg_write, mem_to_reg. Next state is FETCH.
  - MEM_WRITE: mem_write, i_or_d. Next state is FETCH.
  - R_EXEC: alu_src_a, alu_op=10. Next state is R_WB.
  - R_WB: reg_write, reg_dst. Next state is FETCH.
  - BRANCH: alu_src_a, alu_op=01, pc_write_cond, pc_source=01. Next state is FETCH.
  - JUMP: pc_write, pc_source=10. Next state is FETCH.
  - ADDI_EXEC: alu_src_a, alu_src_b=10. Next state is ADDI_WB.
  - ADDI_WB: reg_write. Next state is FETCH.
- `op` is sampled in DECODE and MEM_ADDR only. In MEM_ADDR, `op` is still valid because the IR is held.
- In MEM_ADDR, an op other than lw/sw cannot occur. If it does, the next state is FETCH.
- Unused state encodings go to FETCH on the next edge, with all outputs 0.

## Timing
- Outputs are combinational decodes of the registered state. There is no input-to-output path except `illegal_op` (depends on `op` in DECODE).
- Reset: an edge with rst=1 loads FETCH.
  - While rst=1, pc_write, pc_write_cond, mem_read, mem_write, ir_write and reg_write are forced 0.
  - In the first cycle after release, the FETCH outputs are active.
- Cycles per instruction, FETCH through the final state: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- `op` must be stable from the DECODE cycle until the instruction returns to FETCH.
- Reset takes priority in every state. Asserting reset mid-instruction abandons it with no further write strobes.

## Configuration
- `EE357_MC_MEM_WAIT_EN` defined:
  - The `mem_ready` port exists.
  - FETCH, MEM_READ and MEM_WRITE hold while mem_ready=0. Their strobes stay asserted throughout.
  - In FETCH, ir_write and pc_write assert only in the cycle with mem_ready=1.
  - All CPI figures grow by the number of wait cycles.
- Undefined:
  - The `mem_ready` port is absent and memory is treated as single-cycle (mem_ready≡1).

## Structure
- Package `ee357_mc_pkg` holds:
  - state encoding constants (4-bit),
  - opcode constants,
  - alu_op, alu_src_b and pc_source encodings,
  - a packed control-word typedef.
- Natural sub-module: `ee357_mc_output_decode`, which maps state to the control word. The top holds the state register and next-state logic.

## Test plan
- Reset: rst=1 for 2 cycles → all write strobes 0. After release, state=FETCH, pc_write=1, ir_write=1, alu_src_b=01.
- lw (op=100011) → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. MEM_WB has reg_write=1, mem_to_reg=1, reg_dst=0. Back in FETCH at cycle 6.
- sw, R-type, beq, j, addi each followed by FETCH → sequences of 4/4/3/3/4 states. beq shows pc_write_cond=1, pc_source=01. j shows pc_write=1, pc_source=10.
- op=111111 in DECODE → illegal_op=1 for that cycle, then FETCH, with no reg_write or mem_write pulse.
- rst=1 asserted during R_EXEC → reg_write never asserts, and the state is FETCH after the reset edge.
- With `EE357_MC_MEM_WAIT_EN` defined, mem_ready=0 for 3 cycles in FETCH and then 1 → FETCH held 4 cycles, mem_read high throughout, ir_write/pc_write high only in the 4th cycle. Same hold check for MEM_WRITE.
